// File: rtl/store_port_arbiter.sv
// -----------------------------------------------------------------------------
// store_port_arbiter
//
// Shares the single data-cache write request port between NUM_PORTS store-side
// requesters (store buffer commit queue, AMO unit, CMO/flush unit). A winner is
// picked combinationally and presented to the D$ in the same cycle. If the D$
// does not grant immediately, the selection is locked until it does. After
// every grant the round-robin pointer moves to the port after the granted one.
// flush_i stops new arbitrations but never breaks an existing lock.
//
// Build option:
//   STORE_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 highest, and
//                                          no round-robin pointer.
//                            undefined -> round-robin (default).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              blocks new arbitrations; a locked request completes
//   req_i / gnt_o        per-requester request / one-hot-or-zero grant
//   addr_i, wdata_i,     packed per-requester payload, port k at slice k
//   be_i, size_i
//   dc_req_o, dc_gnt_i   request to / grant from the D$
//   dc_addr_o, dc_wdata_o, dc_be_o, dc_size_o   payload of the selected port
//   sel_idx_o            index of the selected requester (0 when no request)
//   busy_o               high while a selection is locked
// -----------------------------------------------------------------------------
module store_port_arbiter #(
   parameter int unsigned NUM_PORTS = 2,
   // Matches riscv::PLEN of the Sv39 configuration.
   parameter int unsigned ADDR_W    = 56,
   parameter int unsigned DATA_W    = 64,
   localparam int unsigned BE_W     = DATA_W / 8,
   localparam int unsigned IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic [NUM_PORTS-1:0]        req_i,
   output logic [NUM_PORTS-1:0]        gnt_o,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
   input  logic [NUM_PORTS*BE_W-1:0]   be_i,
   input  logic [NUM_PORTS*2-1:0]      size_i,
   output logic                        dc_req_o,
   input  logic                        dc_gnt_i,
   output logic [ADDR_W-1:0]           dc_addr_o,
   output logic [DATA_W-1:0]           dc_wdata_o,
   output logic [BE_W-1:0]             dc_be_o,
   output logic [1:0]                  dc_size_o,
   output logic [IDX_W-1:0]            sel_idx_o,
   output logic                        busy_o
);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_e;

   state_e             r_state;
   logic [IDX_W-1:0]   r_lock_idx;
`ifndef STORE_ARB_FIXED_PRIO_EN
   logic [IDX_W-1:0]   r_rr_ptr;
`endif

   logic [IDX_W-1:0]   w_win_lo;
   logic [IDX_W-1:0]   w_win_hi;
   logic               w_found_hi;
   logic [IDX_W-1:0]   w_winner;
   logic [IDX_W-1:0]   w_sel;
   logic               w_locked;
   logic               w_dc_req;
   logic               w_grant;

`ifndef STORE_ARB_FIXED_PRIO_EN
   function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_PORTS - 1)) ? '0 : idx + IDX_W'(1);
   endfunction
`endif

   // Winner search. w_win_lo is the lowest set request overall; w_win_hi is the
   // lowest set request at or above the pointer. Taking w_win_hi when it exists
   // and w_win_lo otherwise is the wrapping search without any modulo logic.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      //       so no path leaves it unassigned and no latch is inferred.
      w_win_lo   = '0;
      w_win_hi   = '0;
      w_found_hi = 1'b0;
      for (int j = int'(NUM_PORTS) - 1; j >= 0; j--) begin
         if (req_i[j]) begin
            w_win_lo = IDX_W'(j);
`ifndef STORE_ARB_FIXED_PRIO_EN
            if (IDX_W'(j) >= r_rr_ptr) begin
               w_win_hi   = IDX_W'(j);
               w_found_hi = 1'b1;
            end
`endif
         end
      end
      w_winner = w_found_hi ? w_win_hi : w_win_lo;
   end

   assign w_locked = (r_state == S_LOCKED);
   assign w_sel    = w_locked ? r_lock_idx : w_winner;

   // Qualifying with rst_ni drops the combinational outputs as soon as reset
   // asserts, even while requesters still hold their requests.
   assign w_dc_req = rst_ni && (w_locked || ((|req_i) && !flush_i));
   assign w_grant  = w_dc_req && dc_gnt_i;

   assign dc_req_o  = w_dc_req;
   assign busy_o    = w_locked;
   assign sel_idx_o = rst_ni ? w_sel : '0;

   // Payload mux and grant decode.
   always_comb begin
      dc_addr_o  = '0;
      dc_wdata_o = '0;
      dc_be_o    = '0;
      dc_size_o  = '0;
      gnt_o      = '0;
      for (int j = 0; j < int'(NUM_PORTS); j++) begin
         if (w_sel == IDX_W'(j)) begin
            dc_addr_o  = addr_i[j*ADDR_W +: ADDR_W];
            dc_wdata_o = wdata_i[j*DATA_W +: DATA_W];
            dc_be_o    = be_i[j*BE_W +: BE_W];
            dc_size_o  = size_i[j*2 +: 2];
            gnt_o[j]   = w_grant;
         end
      end
   end

   // Control FSM. The pointer and lock index only advance on accepted cycles.
   // NOTE: state registers use non-blocking assignments so every register
   //       samples values from before the clock edge, independent of order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_lock_idx <= '0;
`ifndef STORE_ARB_FIXED_PRIO_EN
         r_rr_ptr   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_dc_req) begin
                  if (dc_gnt_i) begin
`ifndef STORE_ARB_FIXED_PRIO_EN
                     r_rr_ptr <= f_next(w_winner);
`endif
                  end else begin
                     r_lock_idx <= w_winner;
                     r_state    <= S_LOCKED;
                  end
               end
            end
            S_LOCKED: begin
               if (dc_gnt_i) begin
`ifndef STORE_ARB_FIXED_PRIO_EN
                  r_rr_ptr <= f_next(r_lock_idx);
`endif
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // A requester must hold its request until it has been granted.
   for (genvar k = 0; k < int'(NUM_PORTS); k++) begin : g_req_hold
      a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   (req_i[k] && !gnt_o[k]) |=> req_i[k]);
   end
`endif

endmodule

// File: doc/store_port_arbiter.md
# store_port_arbiter

Arbitrates the single data-cache write request port between NUM_PORTS store-side requesters: store buffer commit queue, AMO unit, CMO/flush unit. Sits between those requesters and the D$ request port. Selects one requester and locks the selection until the cache grants it, then advances a round-robin priority pointer. Honours a flush/pause input so that no new store is launched into the cache while the pipeline is being flushed.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters; legal range 1..8.
- ADDR_W, riscv::PLEN: physical address width.
- DATA_W, 64: write data width; byte enables are DATA_W/8 wide.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  blocks starting a new arbitration; a locked request still completes.
- req_i  in  NUM_PORTS  per-requester request.
- gnt_o  out  NUM_PORTS  per-requester grant; one-hot or zero.
- addr_i  in  NUM_PORTS*ADDR_W  packed addresses; port k is at [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_PORTS*DATA_W  packed write data.
- be_i  in  NUM_PORTS*DATA_W/8  packed byte enables.
- size_i  in  NUM_PORTS*2  packed data sizes.
- dc_req_o  out  1  request to the D$.
- dc_gnt_i  in  1  D$ grant.
- dc_addr_o  out  ADDR_W  selected address.
- dc_wdata_o  out  DATA_W  selected data.
- dc_be_o  out  DATA_W/8  selected byte enables.
- dc_size_o  out  2  selected size.
- sel_idx_o  out  max(1,$clog2(NUM_PORTS))  index of the currently selected requester.
- busy_o  out  1  high while in LOCKED.

## Operation
- State machine has two states, IDLE and LOCKED. Registered state: the state itself, rr_ptr, lock_idx.
- Winner selection uses the first set bit of req_i searching from rr_ptr upward, wrapping from NUM_PORTS-1 to 0.
- IDLE:
  - If req_i is nonzero and flush_i=0: dc_req_o=1 and the payload is muxed from the winner.
  - If dc_gnt_i=1 in the same cycle: gnt_o[winner]=1, rr_ptr <= winner+1 (wrapping to 0 after NUM_PORTS-1), and the state stays IDLE.
  - If dc_gnt_i=0: lock_idx <= winner and the state goes to LOCKED.
- IDLE with flush_i=1 or req_i=0: dc_req_o=0, gnt_o=0, no state change.
- LOCKED:
  - dc_req_o=1 and the payload comes from lock_idx.
  - Independent of flush_i and of req_i of other ports.
  - On dc_gnt_i=1: gnt_o[lock_idx]=1, rr_ptr <= lock_idx+1 (wrapping), state goes to IDLE.
- Requester contract: once req_i[k]=1, port k holds req and payload stable until gnt_o[k]. Dropping early is illegal and is checked by assertion. The arbiter never retracts dc_req_o before dc_gnt_i.
- dc_gnt_i while dc_req_o=0 is ignored.
- sel_idx_o equals the winner in IDLE and lock_idx in LOCKED. It is 0 when there is no request.
- NUM_PORTS=1: rr_ptr is constant 0, and the block degenerates to pass-through plus flush gating and locking.

## Timing
- Reset values: state=IDLE, rr_ptr=0, lock_idx=0. All outputs are 0 while there is no request: dc_req_o, gnt_o, sel_idx_o, busy_o, and the payload (muxed from port 0, treated as don't-care).
- Request-to-cache latency is 0 cycles; dc_req_o is combinational from req_i.
- gnt_o is combinational from dc_gnt_i, with 0 cycles of latency.
- Back-to-back grants with no bubble cycle: with dc_gnt_i held at 1, a new winner is chosen every cycle.
- Reset asserted in LOCKED aborts the lock. Outputs drop to 0 asynchronously. The requester must re-present its request after reset.
- flush_i rising while LOCKED does not affect the lock. The flush is honoured on the first IDLE cycle after the lock completes.

## Configuration
- STORE_ARB_FIXED_PRIO_EN defined:
  - rr_ptr is removed.
  - The winner is always the lowest-index set bit of req_i (port 0 has the highest priority; this is meant for the store buffer).
  - Locking and flush behaviour are unchanged.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single request with immediate grant: req_i=01, dc_gnt_i=1, addr_i[0]=0x8000_1000 -> same cycle dc_req_o=1, dc_addr_o=0x8000_1000, gnt_o=01; next cycle rr_ptr=1.
- Locking: req_i=11, dc_gnt_i=0 for 3 cycles, then 1 -> busy_o=1 for 3 cycles, sel_idx_o=0 throughout, gnt_o=01 in cycle 4; next grant goes to port 1.
- Round-robin fairness: NUM_PORTS=3, req_i=111 constant, dc_gnt_i=1 constant -> grants 001,010,100,001 on consecutive cycles, including the wrap 2->0.
- Flush gating: flush_i=1, req_i=10 -> dc_req_o=0, gnt_o=0. Flush asserted while LOCKED on port 1 -> dc_req_o stays 1 until dc_gnt_i, then gnt_o=10.
- Reset mid-lock: LOCKED on port 1, rst_ni low for 1 cycle -> dc_req_o=0, busy_o=0, rr_ptr=0; after release with req_i=11, port 0 wins.
- Fixed priority (STORE_ARB_FIXED_PRIO_EN): req_i=11, dc_gnt_i=1 for 4 cycles -> gnt_o=01 every cycle; port 1 is never granted.
